// File: rtl/control_pipe.sv
// MIPS-I style ID-stage control: instruction decode, EX control register,
// next-PC selection and a multi-cycle multiply/divide occupancy FSM.
module control_pipe #(
    parameter int ALUOP_WIDTH = 5,
    parameter int MUL_LAT     = 4,
    parameter int DIV_LAT     = 32,
    parameter int DELAY_SLOT  = 1
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   ID_Valid,
    input  logic                   ID_Stall,
    input  logic [5:0]             OpCode,
    input  logic [5:0]             Func,
    input  logic                   Comp_EQ,
    output logic [1:0]             PCSrcSel,
    output logic                   IF_Flush,
    output logic                   Stall_Out,
    output logic                   EX_Valid,
    output logic [10:0]            EX_Ctrl,
    output logic [ALUOP_WIDTH-1:0] EX_ALUOp,
    output logic                   MD_Start,
    output logic                   Busy,
    output logic                   HiLo_Write,
    output logic                   Illegal
);

    localparam int MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
    localparam int CNT_W   = $clog2(MAX_LAT + 1);
    localparam logic [CNT_W-1:0] MUL_CNT = CNT_W'(MUL_LAT - 1);
    localparam logic [CNT_W-1:0] DIV_CNT = CNT_W'(DIV_LAT - 1);

    localparam int C_REGWRITE = 0;
    localparam int C_MEMREAD  = 1;
    localparam int C_MEMWRITE = 2;
    localparam int C_MEMTOREG = 3;
    localparam int C_REGDEST  = 4;
    localparam int C_ALUSRC   = 5;
    localparam int C_LINK     = 6;
    localparam int C_MEMBYTE  = 7;
    localparam int C_MEMHALF  = 8;
    localparam int C_MEMSEXT  = 9;
    localparam int C_SIGNEXT  = 10;

    localparam logic [ALUOP_WIDTH-1:0] OP_NOP   = ALUOP_WIDTH'(0);
    localparam logic [ALUOP_WIDTH-1:0] OP_ADD   = ALUOP_WIDTH'(1);
    localparam logic [ALUOP_WIDTH-1:0] OP_ADDU  = ALUOP_WIDTH'(2);
    localparam logic [ALUOP_WIDTH-1:0] OP_SUB   = ALUOP_WIDTH'(3);
    localparam logic [ALUOP_WIDTH-1:0] OP_SUBU  = ALUOP_WIDTH'(4);
    localparam logic [ALUOP_WIDTH-1:0] OP_AND   = ALUOP_WIDTH'(5);
    localparam logic [ALUOP_WIDTH-1:0] OP_OR    = ALUOP_WIDTH'(6);
    localparam logic [ALUOP_WIDTH-1:0] OP_XOR   = ALUOP_WIDTH'(7);
    localparam logic [ALUOP_WIDTH-1:0] OP_NOR   = ALUOP_WIDTH'(8);
    localparam logic [ALUOP_WIDTH-1:0] OP_SLT   = ALUOP_WIDTH'(9);
    localparam logic [ALUOP_WIDTH-1:0] OP_SLTU  = ALUOP_WIDTH'(10);
    localparam logic [ALUOP_WIDTH-1:0] OP_SLL   = ALUOP_WIDTH'(11);
    localparam logic [ALUOP_WIDTH-1:0] OP_SRL   = ALUOP_WIDTH'(12);
    localparam logic [ALUOP_WIDTH-1:0] OP_LUI   = ALUOP_WIDTH'(13);
    localparam logic [ALUOP_WIDTH-1:0] OP_MULT  = ALUOP_WIDTH'(14);
    localparam logic [ALUOP_WIDTH-1:0] OP_MULTU = ALUOP_WIDTH'(15);
    localparam logic [ALUOP_WIDTH-1:0] OP_DIV   = ALUOP_WIDTH'(16);
    localparam logic [ALUOP_WIDTH-1:0] OP_DIVU  = ALUOP_WIDTH'(17);
    localparam logic [ALUOP_WIDTH-1:0] OP_MFHI  = ALUOP_WIDTH'(18);
    localparam logic [ALUOP_WIDTH-1:0] OP_MFLO  = ALUOP_WIDTH'(19);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t                   state_q, state_d;
    logic [CNT_W-1:0]         cnt_q, cnt_d;
    logic                     ex_valid_q, ex_valid_d;
    logic [10:0]              ex_ctrl_q, ex_ctrl_d;
    logic [ALUOP_WIDTH-1:0]   ex_aluop_q, ex_aluop_d;
    logic                     md_start_q, md_start_d;
    logic                     hilo_write_q, hilo_write_d;
    logic                     illegal_q, illegal_d;

    logic [10:0]              ctrl_dec;
    logic [ALUOP_WIDTH-1:0]   aluop_dec;
    logic dec_ok, zero_ext, is_md, is_div, is_mf, is_beq, is_bne, is_jump, is_jr;
    logic busy, go, issue;
    logic [1:0] pc_sel;

    always_comb begin
        ctrl_dec  = '0;
        aluop_dec = OP_NOP;
        dec_ok    = 1'b1;
        zero_ext  = 1'b0;
        is_md     = 1'b0;
        is_div    = 1'b0;
        is_mf     = 1'b0;
        is_beq    = 1'b0;
        is_bne    = 1'b0;
        is_jump   = 1'b0;
        is_jr     = 1'b0;
        case (OpCode)
            6'h00: begin
                ctrl_dec[C_REGWRITE] = 1'b1;
                ctrl_dec[C_REGDEST]  = 1'b1;
                case (Func)
                    6'h20: aluop_dec = OP_ADD;
                    6'h21: aluop_dec = OP_ADDU;
                    6'h22: aluop_dec = OP_SUB;
                    6'h23: aluop_dec = OP_SUBU;
                    6'h24: aluop_dec = OP_AND;
                    6'h25: aluop_dec = OP_OR;
                    6'h26: aluop_dec = OP_XOR;
                    6'h27: aluop_dec = OP_NOR;
                    6'h2A: aluop_dec = OP_SLT;
                    6'h2B: aluop_dec = OP_SLTU;
                    6'h00: aluop_dec = OP_SLL;
                    6'h02: aluop_dec = OP_SRL;
                    6'h10: begin aluop_dec = OP_MFHI; is_mf = 1'b1; end
                    6'h12: begin aluop_dec = OP_MFLO; is_mf = 1'b1; end
                    6'h08: begin
                        is_jr    = 1'b1;
                        ctrl_dec = '0;
                    end
                    6'h18, 6'h19, 6'h1A, 6'h1B: begin
                        is_md    = 1'b1;
                        is_div   = Func[1];
                        ctrl_dec = '0;
                        case (Func[1:0])
                            2'b00:   aluop_dec = OP_MULT;
                            2'b01:   aluop_dec = OP_MULTU;
                            2'b10:   aluop_dec = OP_DIV;
                            default: aluop_dec = OP_DIVU;
                        endcase
                    end
                    default: dec_ok = 1'b0;
                endcase
            end
            6'h08: begin ctrl_dec[C_REGWRITE] = 1'b1; ctrl_dec[C_ALUSRC] = 1'b1; aluop_dec = OP_ADD;  end
            6'h09: begin ctrl_dec[C_REGWRITE] = 1'b1; ctrl_dec[C_ALUSRC] = 1'b1; aluop_dec = OP_ADDU; end
            6'h0A: begin ctrl_dec[C_REGWRITE] = 1'b1; ctrl_dec[C_ALUSRC] = 1'b1; aluop_dec = OP_SLT;  end
            6'h0B: begin ctrl_dec[C_REGWRITE] = 1'b1; ctrl_dec[C_ALUSRC] = 1'b1; aluop_dec = OP_SLTU; end
            6'h0C: begin ctrl_dec[C_REGWRITE] = 1'b1; ctrl_dec[C_ALUSRC] = 1'b1; aluop_dec = OP_AND; zero_ext = 1'b1; end
            6'h0D: begin ctrl_dec[C_REGWRITE] = 1'b1; ctrl_dec[C_ALUSRC] = 1'b1; aluop_dec = OP_OR;  zero_ext = 1'b1; end
            6'h0E: begin ctrl_dec[C_REGWRITE] = 1'b1; ctrl_dec[C_ALUSRC] = 1'b1; aluop_dec = OP_XOR; zero_ext = 1'b1; end
            6'h0F: begin ctrl_dec[C_REGWRITE] = 1'b1; ctrl_dec[C_ALUSRC] = 1'b1; aluop_dec = OP_LUI;  end
            // Loads: OpCode[1:0] picks width (00 byte, 01 half, 11 word), OpCode[2] marks unsigned.
            6'h20, 6'h21, 6'h23, 6'h24, 6'h25: begin
                ctrl_dec[C_REGWRITE] = 1'b1;
                ctrl_dec[C_MEMREAD]  = 1'b1;
                ctrl_dec[C_MEMTOREG] = 1'b1;
                ctrl_dec[C_ALUSRC]   = 1'b1;
                ctrl_dec[C_MEMBYTE]  = (OpCode[1:0] == 2'b00);
                ctrl_dec[C_MEMHALF]  = (OpCode[1:0] == 2'b01);
                ctrl_dec[C_MEMSEXT]  = !OpCode[2] && !OpCode[1];
                aluop_dec            = OP_ADDU;
            end
            6'h28, 6'h29, 6'h2B: begin
                ctrl_dec[C_MEMWRITE] = 1'b1;
                ctrl_dec[C_ALUSRC]   = 1'b1;
                ctrl_dec[C_MEMBYTE]  = (OpCode[1:0] == 2'b00);
                ctrl_dec[C_MEMHALF]  = (OpCode[1:0] == 2'b01);
                aluop_dec            = OP_ADDU;
            end
            6'h04: begin is_beq = 1'b1; aluop_dec = OP_SUBU; end
            6'h05: begin is_bne = 1'b1; aluop_dec = OP_SUBU; end
            6'h02: is_jump = 1'b1;
            6'h03: begin
                is_jump              = 1'b1;
                ctrl_dec[C_REGWRITE] = 1'b1;
                ctrl_dec[C_LINK]     = 1'b1;
                aluop_dec            = OP_ADDU;
            end
            default: dec_ok = 1'b0;
        endcase
        if (dec_ok) begin
            ctrl_dec[C_SIGNEXT] = !zero_ext;
        end else begin
            ctrl_dec  = '0;
            aluop_dec = OP_NOP;
        end
    end

    assign busy      = (state_q == BUSY);
    assign Stall_Out = ID_Valid && busy && (is_md || is_mf);
    assign go        = ID_Valid && !(ID_Stall || Stall_Out);
    assign issue     = go && dec_ok;

    always_comb begin
        pc_sel = 2'b00;
        if (go) begin
            if ((is_beq && Comp_EQ) || (is_bne && !Comp_EQ)) pc_sel = 2'b01;
            else if (is_jump)                                 pc_sel = 2'b10;
            else if (is_jr)                                   pc_sel = 2'b11;
        end
    end

    assign PCSrcSel = pc_sel;
    assign IF_Flush = (DELAY_SLOT == 0) && (pc_sel != 2'b00);

    // Only one multiply/divide can be in flight: new ones stall while BUSY.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        md_start_d   = 1'b0;
        hilo_write_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (issue && is_md) begin
                    state_d    = BUSY;
                    cnt_d      = is_div ? DIV_CNT : MUL_CNT;
                    md_start_d = 1'b1;
                end
            end
            BUSY: begin
                if (cnt_q == '0) begin
                    hilo_write_d = 1'b1;
                    state_d      = IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        ex_valid_d = issue;
        ex_ctrl_d  = issue ? ctrl_dec : '0;
        ex_aluop_d = issue ? aluop_dec : OP_NOP;
        illegal_d  = go && !dec_ok;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            ex_valid_q   <= 1'b0;
            ex_ctrl_q    <= '0;
            ex_aluop_q   <= '0;
            md_start_q   <= 1'b0;
            hilo_write_q <= 1'b0;
            illegal_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            ex_valid_q   <= ex_valid_d;
            ex_ctrl_q    <= ex_ctrl_d;
            ex_aluop_q   <= ex_aluop_d;
            md_start_q   <= md_start_d;
            hilo_write_q <= hilo_write_d;
            illegal_q    <= illegal_d;
        end
    end

    assign EX_Valid   = ex_valid_q;
    assign EX_Ctrl    = ex_ctrl_q;
    assign EX_ALUOp   = ex_aluop_q;
    assign MD_Start   = md_start_q;
    assign Busy       = busy;
    assign HiLo_Write = hilo_write_q;
    assign Illegal    = illegal_q;

endmodule

// File: tb/tb_control_pipe.sv
// Directed bench for control_pipe: default instance plus a DELAY_SLOT=0,
// latency-1 instance sharing the same inputs.
module tb_control_pipe;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        ID_Valid = 1'b0;
    logic        ID_Stall = 1'b0;
    logic [5:0]  OpCode = '0;
    logic [5:0]  Func = '0;
    logic        Comp_EQ = 1'b0;

    logic [1:0]  pc_sel, ns_pc_sel;
    logic        if_flush, ns_if_flush;
    logic        stall_out, ns_stall_out;
    logic        ex_valid, ns_ex_valid;
    logic [10:0] ex_ctrl, ns_ex_ctrl;
    logic [4:0]  ex_aluop, ns_ex_aluop;
    logic        md_start, ns_md_start;
    logic        busy, ns_busy;
    logic        hilo_write, ns_hilo_write;
    logic        illegal, ns_illegal;

    int checks = 0;
    int fails  = 0;

    always #5 clock = ~clock;

    control_pipe u_dut (
        .clock(clock), .reset(reset), .ID_Valid(ID_Valid), .ID_Stall(ID_Stall),
        .OpCode(OpCode), .Func(Func), .Comp_EQ(Comp_EQ),
        .PCSrcSel(pc_sel), .IF_Flush(if_flush), .Stall_Out(stall_out),
        .EX_Valid(ex_valid), .EX_Ctrl(ex_ctrl), .EX_ALUOp(ex_aluop),
        .MD_Start(md_start), .Busy(busy), .HiLo_Write(hilo_write), .Illegal(illegal)
    );

    control_pipe #(.MUL_LAT(1), .DIV_LAT(1), .DELAY_SLOT(0)) u_dut_ns (
        .clock(clock), .reset(reset), .ID_Valid(ID_Valid), .ID_Stall(ID_Stall),
        .OpCode(OpCode), .Func(Func), .Comp_EQ(Comp_EQ),
        .PCSrcSel(ns_pc_sel), .IF_Flush(ns_if_flush), .Stall_Out(ns_stall_out),
        .EX_Valid(ns_ex_valid), .EX_Ctrl(ns_ex_ctrl), .EX_ALUOp(ns_ex_aluop),
        .MD_Start(ns_md_start), .Busy(ns_busy), .HiLo_Write(ns_hilo_write), .Illegal(ns_illegal)
    );

    typedef struct {
        string       name;
        logic        valid;
        logic [5:0]  op;
        logic [5:0]  fn;
        logic        ceq;
        logic        stl;
        logic        exp_v;
        logic [10:0] exp_ctrl;
        logic [4:0]  exp_alu;
        logic [1:0]  exp_pc;
        logic        exp_ill;
    } vec_t;

    vec_t vecs[$];

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic v, input logic [5:0] op, input logic [5:0] fn,
                                 input logic ceq, input logic stl);
        ID_Valid = v;
        OpCode   = op;
        Func     = fn;
        Comp_EQ  = ceq;
        ID_Stall = stl;
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    function automatic void addVec(string name, logic valid, logic [5:0] op, logic [5:0] fn,
                                   logic ceq, logic stl, logic exp_v, logic [10:0] exp_ctrl,
                                   logic [4:0] exp_alu, logic [1:0] exp_pc, logic exp_ill);
        vec_t t;
        t.name = name; t.valid = valid; t.op = op; t.fn = fn; t.ceq = ceq; t.stl = stl;
        t.exp_v = exp_v; t.exp_ctrl = exp_ctrl; t.exp_alu = exp_alu; t.exp_pc = exp_pc;
        t.exp_ill = exp_ill;
        vecs.push_back(t);
    endfunction

    int hilo_seen;

    initial begin
        addVec("add",      1, 6'h00, 6'h20, 0, 0, 1, 11'h411, 5'd1,  2'b00, 0);
        addVec("subu",     1, 6'h00, 6'h23, 0, 0, 1, 11'h411, 5'd4,  2'b00, 0);
        addVec("sll",      1, 6'h00, 6'h00, 0, 0, 1, 11'h411, 5'd11, 2'b00, 0);
        addVec("jr",       1, 6'h00, 6'h08, 0, 0, 1, 11'h400, 5'd0,  2'b11, 0);
        addVec("mfhi",     1, 6'h00, 6'h10, 0, 0, 1, 11'h411, 5'd18, 2'b00, 0);
        addVec("addi",     1, 6'h08, 6'h00, 0, 0, 1, 11'h421, 5'd1,  2'b00, 0);
        addVec("andi",     1, 6'h0C, 6'h00, 0, 0, 1, 11'h021, 5'd5,  2'b00, 0);
        addVec("xori",     1, 6'h0E, 6'h00, 0, 0, 1, 11'h021, 5'd7,  2'b00, 0);
        addVec("lui",      1, 6'h0F, 6'h00, 0, 0, 1, 11'h421, 5'd13, 2'b00, 0);
        addVec("lb",       1, 6'h20, 6'h00, 0, 0, 1, 11'h6AB, 5'd2,  2'b00, 0);
        addVec("lhu",      1, 6'h25, 6'h00, 0, 0, 1, 11'h52B, 5'd2,  2'b00, 0);
        addVec("lw",       1, 6'h23, 6'h00, 0, 0, 1, 11'h42B, 5'd2,  2'b00, 0);
        addVec("sb",       1, 6'h28, 6'h00, 0, 0, 1, 11'h4A4, 5'd2,  2'b00, 0);
        addVec("sw",       1, 6'h2B, 6'h00, 0, 0, 1, 11'h424, 5'd2,  2'b00, 0);
        addVec("beq_t",    1, 6'h04, 6'h00, 1, 0, 1, 11'h400, 5'd4,  2'b01, 0);
        addVec("beq_nt",   1, 6'h04, 6'h00, 0, 0, 1, 11'h400, 5'd4,  2'b00, 0);
        addVec("bne_t",    1, 6'h05, 6'h00, 0, 0, 1, 11'h400, 5'd4,  2'b01, 0);
        addVec("j",        1, 6'h02, 6'h00, 0, 0, 1, 11'h400, 5'd0,  2'b10, 0);
        addVec("jal",      1, 6'h03, 6'h00, 0, 0, 1, 11'h441, 5'd2,  2'b10, 0);
        addVec("ill_op",   1, 6'h3F, 6'h00, 0, 0, 0, 11'h000, 5'd0,  2'b00, 1);
        addVec("ill_fn",   1, 6'h00, 6'h3F, 0, 0, 0, 11'h000, 5'd0,  2'b00, 1);
        addVec("xor_stl",  1, 6'h00, 6'h26, 0, 1, 0, 11'h000, 5'd0,  2'b00, 0);
        addVec("j_stl",    1, 6'h02, 6'h00, 0, 1, 0, 11'h000, 5'd0,  2'b00, 0);
        addVec("jr_inval", 0, 6'h00, 6'h08, 0, 0, 0, 11'h000, 5'd0,  2'b00, 0);

        // Reset: registers cleared, combinational PC select still live.
        #1 reset = 1'b1;
        applyStimulus(1, 6'h02, 6'h00, 0, 0);
        #2;
        checkOutput("rst_ex_valid", ex_valid, 0);
        checkOutput("rst_ex_ctrl", ex_ctrl, 0);
        checkOutput("rst_ex_aluop", ex_aluop, 0);
        checkOutput("rst_md_start", md_start, 0);
        checkOutput("rst_hilo", hilo_write, 0);
        checkOutput("rst_illegal", illegal, 0);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_pcsel", pc_sel, 2'b10);
        checkOutput("rst_ns_flush", ns_if_flush, 1);
        tick();
        checkOutput("rst_hold_ex_valid", ex_valid, 0);
        applyStimulus(0, 6'h00, 6'h00, 0, 0);
        reset = 1'b0;

        // Single-cycle decode table.
        foreach (vecs[i]) begin
            applyStimulus(vecs[i].valid, vecs[i].op, vecs[i].fn, vecs[i].ceq, vecs[i].stl);
            #1;
            checkOutput({vecs[i].name, "/pcsel"}, pc_sel, vecs[i].exp_pc);
            checkOutput({vecs[i].name, "/flush"}, if_flush, 0);
            checkOutput({vecs[i].name, "/ns_flush"}, ns_if_flush, (vecs[i].exp_pc != 2'b00));
            checkOutput({vecs[i].name, "/stall_out"}, stall_out, 0);
            tick();
            checkOutput({vecs[i].name, "/ex_valid"}, ex_valid, vecs[i].exp_v);
            checkOutput({vecs[i].name, "/ex_ctrl"}, ex_ctrl, vecs[i].exp_ctrl);
            checkOutput({vecs[i].name, "/ex_aluop"}, ex_aluop, vecs[i].exp_alu);
            checkOutput({vecs[i].name, "/illegal"}, illegal, vecs[i].exp_ill);
            checkOutput({vecs[i].name, "/md_start"}, md_start, 0);
        end

        // Stall then release of XOR.
        applyStimulus(1, 6'h00, 6'h26, 0, 1);
        tick();
        checkOutput("xor_held", ex_valid, 0);
        applyStimulus(1, 6'h00, 6'h26, 0, 0);
        tick();
        checkOutput("xor_release_valid", ex_valid, 1);
        checkOutput("xor_release_alu", ex_aluop, 5'd7);

        // MULT followed by independent ADDU, LW, SW.
        applyStimulus(1, 6'h00, 6'h18, 0, 0);
        #1 checkOutput("mult_stall", stall_out, 0);
        tick();
        checkOutput("mult_md_start", md_start, 1);
        checkOutput("mult_busy", busy, 1);
        checkOutput("mult_alu", ex_aluop, 5'd14);
        checkOutput("ns_mult_md_start", ns_md_start, 1);
        checkOutput("ns_mult_busy", ns_busy, 1);
        applyStimulus(1, 6'h00, 6'h21, 0, 0);
        #1 checkOutput("addu_stall", stall_out, 0);
        tick();
        checkOutput("addu_valid", ex_valid, 1);
        checkOutput("addu_alu", ex_aluop, 5'd2);
        checkOutput("addu_md_start", md_start, 0);
        checkOutput("addu_busy", busy, 1);
        checkOutput("addu_hilo", hilo_write, 0);
        checkOutput("ns_lat1_hilo", ns_hilo_write, 1);
        checkOutput("ns_lat1_busy", ns_busy, 0);
        applyStimulus(1, 6'h23, 6'h00, 0, 0);
        #1 checkOutput("lw_stall", stall_out, 0);
        tick();
        checkOutput("lw_ctrl", ex_ctrl, 11'h42B);
        checkOutput("lw_busy", busy, 1);
        checkOutput("ns_lat1_hilo_once", ns_hilo_write, 0);
        applyStimulus(1, 6'h2B, 6'h00, 0, 0);
        #1 checkOutput("sw_stall", stall_out, 0);
        tick();
        checkOutput("sw_ctrl", ex_ctrl, 11'h424);
        checkOutput("sw_busy", busy, 1);
        checkOutput("sw_hilo", hilo_write, 0);
        applyStimulus(0, 6'h00, 6'h00, 0, 0);
        tick();
        checkOutput("mult_hilo", hilo_write, 1);
        checkOutput("mult_done_busy", busy, 0);
        tick();
        checkOutput("mult_hilo_pulse", hilo_write, 0);

        // DIV followed by dependent MFLO; ID_Stall mid-way must not pause the count.
        applyStimulus(1, 6'h00, 6'h1A, 0, 0);
        tick();
        checkOutput("div_md_start", md_start, 1);
        checkOutput("div_alu", ex_aluop, 5'd16);
        for (int i = 1; i <= 32; i++) begin
            applyStimulus(1, 6'h00, 6'h12, 0, (i >= 5 && i <= 8));
            #1;
            checkOutput($sformatf("mflo_stall_%0d", i), stall_out, 1);
            tick();
            checkOutput($sformatf("mflo_bubble_%0d", i), ex_valid, 0);
            checkOutput($sformatf("div_busy_%0d", i), busy, (i < 32));
            checkOutput($sformatf("div_hilo_%0d", i), hilo_write, (i == 32));
        end
        applyStimulus(1, 6'h00, 6'h12, 0, 0);
        #1 checkOutput("mflo_free", stall_out, 0);
        tick();
        checkOutput("mflo_issue_valid", ex_valid, 1);
        checkOutput("mflo_issue_alu", ex_aluop, 5'd19);
        checkOutput("mflo_issue_ctrl", ex_ctrl, 11'h411);
        checkOutput("mflo_hilo_pulse", hilo_write, 0);

        // Reset during the tenth busy cycle of a DIV aborts it.
        applyStimulus(1, 6'h00, 6'h1B, 0, 0);
        tick();
        checkOutput("divu_md_start", md_start, 1);
        applyStimulus(0, 6'h00, 6'h00, 0, 0);
        repeat (9) tick();
        checkOutput("divu_busy_c10", busy, 1);
        applyStimulus(1, 6'h00, 6'h3F, 0, 0);
        #2 reset = 1'b1;
        #1;
        checkOutput("abort_busy", busy, 0);
        checkOutput("abort_hilo", hilo_write, 0);
        checkOutput("abort_pcsel", pc_sel, 0);
        checkOutput("abort_stall", stall_out, 0);
        tick();
        reset = 1'b0;
        tick();
        checkOutput("post_rst_illegal", illegal, 1);
        checkOutput("post_rst_bubble", ex_valid, 0);
        checkOutput("post_rst_ctrl", ex_ctrl, 0);
        applyStimulus(0, 6'h00, 6'h00, 0, 0);
        tick();
        checkOutput("illegal_pulse", illegal, 0);
        hilo_seen = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (hilo_write === 1'b1) hilo_seen++;
        end
        checkOutput("no_hilo_after_abort", hilo_seen, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
